i2c_target_regs: RTL
====================

# i2c_target_regs

I2C write-only target (responder) that decodes the SCL/SDA stream produced by the team's I2C pulse generators. It recognises START/STOP, matches a 7-bit device address, ACKs by pulling SDA low, and writes received bytes into a small bank of byte registers that mirror an I/O-expander register map. It is used as the on-board loop-back target for generator bring-up and as a drop-in expander model.

## Interface
- `DEV_ADDR`, `7'h20`: 7-bit target address (write byte `0x40`).
- `NUM_REGS`, `4`: number of 8-bit registers. Must be a power of 2, at most 256.
- `REG_RESET`, `8'hFF`: reset value of every register.
- `FILTER_LEN`, `4`: `clk_in` cycles a synchronised line must hold a new level before the filtered value follows it.
- `clk_in`, input, 1: system clock. The only clock.
- `reset_in`, input, 1: reset, synchronous and active-low.
- `scl_in`, input, 1: I2C clock line, asynchronous.
- `sda_in`, input, 1: I2C data line, asynchronous.
- `sda_oe_out`, output, 1: 1 means drive SDA low (open-drain). Reset value 0.
- `regs_out`, output, 8*NUM_REGS: register bank, reg0 in bits [7:0]. Reset value all `REG_RESET`.
- `wr_stb_out`, output, 1: single-cycle register-write strobe. Reset value 0.
- `wr_addr_out`, output, 8: register index of the last write. Reset value 0.
- `wr_data_out`, output, 8: data of the last write. Reset value 0.
- `busy_out`, output, 1: 1 between START and STOP. Reset value 0.

## Operation
- **Line conditioning.** Each line passes through a 2-FF synchroniser, then a glitch filter.
  - The filtered value changes only after the synchronised value has differed from it for `FILTER_LEN` consecutive cycles.
  - Edges are detected on the filtered signals by comparison with the previous cycle.
- **START.** Filtered SDA falls while filtered SCL is 1 in both the previous and current cycle.
  - Valid in any state, including repeated START.
  - Effects: go to ADDR, clear the bit counter, `sda_oe_out` set to 0, `busy_out` set to 1.
- **STOP.** Filtered SDA rises while filtered SCL is 1 in both cycles.
  - Valid in any state.
  - Effects: go to IDLE, `sda_oe_out` set to 0, `busy_out` set to 0.
- **Simultaneous edges.** If SCL and SDA change in the same filtered cycle, this is neither START nor STOP. Only the SCL edge is processed.
- **Data sampling.** Bits are sampled MSB first on the SCL rising edge. The counter counts 0..7, then the ACK slot.
- **State machine.** States are IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, DATA, DATA_ACK, IGNORE.
  - **IDLE:** wait for START.
  - **ADDR, 8 bits received:**
    - Address matches `DEV_ADDR` and R/W=0: go to ADDR_ACK.
    - Otherwise (mismatch or R/W=1): go to IGNORE, no ACK.
  - **PTR, 8 bits received:**
    - Value < `NUM_REGS`: load the pointer and go to PTR_ACK.
    - Otherwise: go to IGNORE, no ACK.
  - **DATA, 8 bits received:**
    - Write to `regs[ptr]`.
    - Pulse `wr_stb_out`, with `wr_addr_out`=ptr and `wr_data_out`=byte.
    - Set ptr = (ptr+1) mod `NUM_REGS` (wraps), then go to DATA_ACK.
  - **\*_ACK states:**
    - On the SCL falling edge that ends bit 7, set `sda_oe_out` to 1.
    - On the next SCL falling edge (end of the 9th clock), set `sda_oe_out` to 0.
    - ADDR_ACK goes to PTR; PTR_ACK and DATA_ACK go to DATA.
  - **IGNORE:** `sda_oe_out` stays 0. Wait for START or STOP.
- **Register persistence.** The pointer and registers persist across transactions. Only reset restores `REG_RESET`.
- **Reset mid-transfer.** All state is forced to reset values at the next `clk_in` edge, including releasing SDA.

## Timing
- Input latency from pin to filtered signal: 2 + `FILTER_LEN` cycles.
- `wr_stb_out` is high for exactly one cycle. That cycle is the cycle after the filtered SCL rising edge that samples data bit 0 (the LSB).
- `regs_out` updates in the same cycle as `wr_stb_out`.
- `sda_oe_out` is registered. It changes one cycle after the filtered SCL falling edge.
- Minimum supported SCL high and low time: `FILTER_LEN`+4 `clk_in` cycles. Nominal generator timing (32 cycles per phase) is well inside this.
- A START/STOP takes effect one cycle after the filtered SDA edge.

## Structure
- Package `i2c_pkg`:
  - state enumeration;
  - `I2C_ACK_BIT`/bit-count constants;
  - default `DEV_ADDR` value, shared with the generators' command constants.
- Sub-module `i2c_line_filter`: synchroniser plus glitch filter, parameter `FILTER_LEN`. Instantiated once for SCL and once for SDA, each output a filtered level.
- Top level contains the edge detection, FSM, shift register, pointer and register bank.

## Test plan
- **Single write.** START, `0x40`, `0x03`, `0x00`, STOP.
  - Required: ACK (`sda_oe_out`=1) in all three 9th clocks.
  - Required: reg3=`0x00`, others `0xFF`.
  - Required: one `wr_stb_out` with addr 3, data `0x00`.
- **Address mismatch.** START, `0x42`, `0x03`, `0x00`, STOP.
  - Required: `sda_oe_out` never asserts, no strobe, `regs_out` unchanged.
- **Auto-increment with wrap.** START, `0x40`, `0x03`, `0xAA`, `0x55`, STOP.
  - Required: reg3=`0xAA`, reg0=`0x55`.
  - Required: two strobes, addr 3 then addr 0.
- **Read bit and bad pointer.**
  - `0x41` leads to NACK and IGNORE until STOP.
  - `0x40` then pointer `0x05` gives ACK then NACK; the following `0x12` causes no write.
- **Robustness.**
  - A 2-cycle SCL glitch mid-byte is ignored and the byte is received correctly.
  - A repeated START after `0x40 0x01` restarts at ADDR without writing.
- **Reset mid-transfer.** Drop `reset_in` during a DATA_ACK.
  - Required on the next edge: `sda_oe_out`=0, `busy_out`=0, all regs `0xFF`.
  - Required: a subsequent full write succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, bit-count constants and the
// default expander device address, also used by the pulse generators.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam int unsigned I2C_BITS_PER_BYTE = 8;
  // Bit-counter value that marks the ninth (acknowledge) clock.
  localparam int unsigned I2C_ACK_BIT       = 8;
  localparam int unsigned I2C_CNT_W         = 4;

  localparam logic [6:0]  I2C_DEV_ADDR      = 7'h20;
  localparam logic        I2C_WRITE         = 1'b0;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a persistence glitch filter.
//   clk_in   : system clock
//   reset_in : synchronous active-low reset (filtered level resets to 1, idle bus)
//   line_in  : asynchronous bus line
//   filt_out : filtered level; follows the synchronised line only after it has
//              differed for FILTER_LEN consecutive cycles
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic line_in,
  output logic filt_out
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      // Count consecutive disagreeing cycles; any agreement restarts the count.
      if (sync2_q != filt_q) begin
        if (cnt_q == CW'(FILTER_LEN - 1)) begin
          filt_q <= sync2_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign filt_out = filt_q;

endmodule

// File: rtl/i2c_target_regs.sv
// Write-only I2C target backed by a small byte-register bank (I/O expander map).
//   clk_in, reset_in : clock, synchronous active-low reset
//   scl_in, sda_in   : asynchronous bus lines
//   sda_oe_out       : 1 pulls SDA low (ACK)
//   regs_out         : register bank, reg0 in [7:0]
//   wr_stb_out       : one-cycle write strobe with wr_addr_out / wr_data_out
//   busy_out         : high between START and STOP
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = I2C_DEV_ADDR,
  parameter int unsigned NUM_REGS   = 4,
  parameter logic [7:0]  REG_RESET  = 8'hFF,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe_out,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  wr_stb_out,
  output logic [7:0]            wr_addr_out,
  output logic [7:0]            wr_data_out,
  output logic                  busy_out
);

  localparam int unsigned PW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]  ADDR_WR = {DEV_ADDR, I2C_WRITE};

  logic scl_f;
  logic sda_f;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .line_in  (scl_in),
    .filt_out (scl_f)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .line_in  (sda_in),
    .filt_out (sda_f)
  );

  i2c_state_e           state_q;
  logic                 scl_p_q;
  logic                 sda_p_q;
  logic [I2C_CNT_W-1:0] cnt_q;
  logic [6:0]           shift_q;
  logic [PW-1:0]        ptr_q;
  logic [7:0]           regs_q [NUM_REGS];
  logic                 sda_oe_q;
  logic                 busy_q;
  logic                 wr_stb_q;
  logic [7:0]           wr_addr_q;
  logic [7:0]           wr_data_q;

  // Edge detection on filtered lines; START/STOP need SCL steady high, so a
  // simultaneous SCL edge can never be taken as START/STOP.
  logic scl_rise_c;
  logic scl_fall_c;
  logic start_c;
  logic stop_c;
  logic [7:0] byte_c;

  assign scl_rise_c = scl_f & ~scl_p_q;
  assign scl_fall_c = ~scl_f & scl_p_q;
  assign start_c    = ~sda_f & sda_p_q & scl_f & scl_p_q;
  assign stop_c     = sda_f & ~sda_p_q & scl_f & scl_p_q;
  assign byte_c     = {shift_q, sda_f};

  // Bus FSM, shifter, pointer and register bank.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q   <= ST_IDLE;
      scl_p_q   <= 1'b1;
      sda_p_q   <= 1'b1;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET;
    end else begin
      scl_p_q  <= scl_f;
      sda_p_q  <= sda_f;
      wr_stb_q <= 1'b0;
      if (start_c) begin
        state_q  <= ST_ADDR;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b1;
      end else if (stop_c) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR, ST_PTR, ST_DATA: begin
            if (scl_rise_c) begin
              shift_q <= byte_c[6:0];
              cnt_q   <= cnt_q + I2C_CNT_W'(1);
              if (cnt_q == I2C_CNT_W'(I2C_BITS_PER_BYTE - 1)) begin
                cnt_q <= I2C_CNT_W'(I2C_ACK_BIT);
                case (state_q)
                  ST_ADDR: state_q <= (byte_c == ADDR_WR) ? ST_ADDR_ACK : ST_IGNORE;
                  ST_PTR: begin
                    if ({1'b0, byte_c} < 9'(NUM_REGS)) begin
                      ptr_q   <= PW'(byte_c);
                      state_q <= ST_PTR_ACK;
                    end else begin
                      state_q <= ST_IGNORE;
                    end
                  end
                  default: begin
                    regs_q[ptr_q] <= byte_c;
                    wr_stb_q      <= 1'b1;
                    wr_addr_q     <= 8'(ptr_q);
                    wr_data_q     <= byte_c;
                    ptr_q         <= ptr_q + PW'(1);
                    state_q       <= ST_DATA_ACK;
                  end
                endcase
              end
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_DATA_ACK: begin
            // First falling edge opens the ACK slot, the second closes it.
            if (scl_fall_c) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                cnt_q    <= '0;
                state_q  <= (state_q == ST_ADDR_ACK) ? ST_PTR : ST_DATA;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_out[8*g +: 8] = regs_q[g];
  end

  assign sda_oe_out  = sda_oe_q;
  assign busy_out    = busy_q;
  assign wr_stb_out  = wr_stb_q;
  assign wr_addr_out = wr_addr_q;
  assign wr_data_out = wr_data_q;

endmodule
